// File: rtl/bpw_pkg.sv
// Shared encodings, command layout and LFSR taps
// for the burst pattern writer.
package bpw_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_INCR   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_CONST  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CMD_WIDTH    = 130;
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_LEN_LSB  = 64;
    localparam int CMD_SEED_LSB = 96;
    localparam int CMD_MODE_LSB = 128;

    // Fibonacci tap masks; bit n-1 set for polynomial term x^n.
    function automatic logic [127:0] lfsr_taps(input int width);
        logic [127:0] t;
        t = '0;
        case (width)
            64: begin
                t[63] = 1'b1;
                t[62] = 1'b1;
                t[60] = 1'b1;
                t[59] = 1'b1;
            end
            128: begin
                t[127] = 1'b1;
                t[125] = 1'b1;
                t[100] = 1'b1;
                t[98]  = 1'b1;
            end
            default: begin
                t[31] = 1'b1;
                t[21] = 1'b1;
                t[1]  = 1'b1;
                t[0]  = 1'b1;
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/bpw_fifo.sv
// Show-ahead FIFO with occupancy count; a push is
// accepted when full as long as a pop happens too.
module bpw_fifo
    import bpw_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/burst_pattern_writer.sv
// Avalon-MM burst write master fed by a stream sink or a
// pattern generator, with bursts realigned to block boundaries.
module burst_pattern_writer
    import bpw_pkg::*;
#(
    parameter int ADDRESS_WIDTH          = 32,
    parameter int LENGTH_WIDTH           = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int BYTE_ENABLE_WIDTH      = DATA_WIDTH / 8,
    parameter int BYTE_ENABLE_WIDTH_LOG2 = $clog2(BYTE_ENABLE_WIDTH),
    parameter int MAX_BURST_COUNT        = 4,
    parameter int BURST_WIDTH            = $clog2(MAX_BURST_COUNT) + 1,
    parameter int FIFO_DEPTH             = 16,
    parameter int FIFO_DEPTH_LOG2        = $clog2(FIFO_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CMD_WIDTH-1:0]         snk_command_data,
    input  logic                         snk_command_valid,
    output logic                         snk_command_ready,
    input  logic [DATA_WIDTH-1:0]        snk_data,
    input  logic                         snk_valid,
    output logic                         snk_ready,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    output logic [LENGTH_WIDTH-1:0]      src_response_data,
    output logic                         src_response_valid
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] TAPS =
        DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
    localparam logic [ADDRESS_WIDTH-1:0] BLK_MASK =
        ADDRESS_WIDTH'(MAX_BURST_COUNT - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK =
        ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH - 1);

    state_t state;
    state_t state_nxt;
    mode_t  mode;
    mode_t  cmd_mode;

    logic [ADDRESS_WIDTH-1:0]     addr;
    logic [ADDRESS_WIDTH-1:0]     burst_addr;
    logic [ADDRESS_WIDTH-1:0]     cmd_addr;
    logic [LENGTH_WIDTH-1:0]      length;
    logic [LENGTH_WIDTH-1:0]      cmd_len;
    logic [LENGTH_WIDTH-1:0]      cmd_words;
    logic [LENGTH_WIDTH-1:0]      fill_left;
    logic [LENGTH_WIDTH-1:0]      write_left;
    logic [LENGTH_WIDTH-1:0]      wl_eff;
    logic [31:0]                  seed;
    logic [31:0]                  cmd_seed;
    logic [DATA_WIDTH-1:0]        gen;
    logic [DATA_WIDTH-1:0]        lfsr_next;
    logic [DATA_WIDTH-1:0]        push_data;
    logic [DATA_WIDTH-1:0]        fifo_q;
    logic [BYTE_ENABLE_WIDTH-1:0] last_be;
    logic [BYTE_ENABLE_WIDTH_LOG2-1:0] cmd_rem;
    logic [BURST_WIDTH-1:0]       beats_left;
    logic [BURST_WIDTH-1:0]       burst_cnt;
    logic [BURST_WIDTH-1:0]       blk_off;
    logic [BURST_WIDTH-1:0]       to_bound;
    logic [BURST_WIDTH-1:0]       bc;
    logic [CW-1:0]                fifo_count;
    logic [CW-1:0]                occ_eff;
    logic                         in_burst;
    logic                         accept;
    logic                         beat;
    logic                         last_beat;
    logic                         launch;
    logic                         room;
    logic                         push;
    logic                         unused_cmd;

    assign cmd_addr   = snk_command_data[CMD_ADDR_LSB +: ADDRESS_WIDTH];
    assign cmd_len    = snk_command_data[CMD_LEN_LSB +: LENGTH_WIDTH];
    assign cmd_seed   = snk_command_data[CMD_SEED_LSB +: 32];
    assign cmd_mode   = mode_t'(snk_command_data[CMD_MODE_LSB +: 2]);
    assign cmd_rem    = cmd_len[BYTE_ENABLE_WIDTH_LOG2-1:0];
    assign unused_cmd = ^snk_command_data;
    assign cmd_words  = (cmd_len >> BYTE_ENABLE_WIDTH_LOG2)
                      + LENGTH_WIDTH'(|cmd_rem);

    assign accept    = (state == ST_IDLE) && snk_command_valid;
    assign beat      = in_burst && !master_waitrequest;
    assign last_beat = beat && (beats_left == BURST_WIDTH'(1));

    // Launch decisions look past the beat completing this cycle so
    // a new burst can follow the previous one without a gap.
    assign wl_eff   = write_left - LENGTH_WIDTH'(beat);
    assign occ_eff  = fifo_count - CW'(beat);
    assign blk_off  = BURST_WIDTH'((addr >> BYTE_ENABLE_WIDTH_LOG2) & BLK_MASK);
    assign to_bound = BURST_WIDTH'(MAX_BURST_COUNT) - blk_off;
    assign bc       = (wl_eff < LENGTH_WIDTH'(to_bound))
                    ? BURST_WIDTH'(wl_eff) : to_bound;
    assign launch   = (state == ST_RUN) && (!in_burst || last_beat)
                    && (wl_eff != '0) && (occ_eff >= CW'(bc));

    assign room      = (fifo_count != FIFO_FULL) || beat;
    assign snk_ready = (state == ST_RUN) && (mode == MODE_STREAM)
                     && (fifo_count != FIFO_FULL) && (fill_left != '0);
    assign push      = (state == ST_RUN) && (fill_left != '0)
                     && ((mode == MODE_STREAM) ? snk_valid && snk_ready : room);
    assign lfsr_next = {gen[DATA_WIDTH-2:0], ^(gen & TAPS)};

    always_comb begin
        push_data = gen;
        unique case (1'b1)
            mode == MODE_STREAM: push_data = snk_data;
            mode == MODE_CONST:  push_data = {(DATA_WIDTH / 32){seed}};
            default:             push_data = gen;
        endcase
    end

    bpw_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_data),
        .pop   (beat),
        .rdata (fifo_q),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (snk_command_valid) begin
                    state_nxt = (cmd_len == '0) ? ST_RESP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat && (write_left == LENGTH_WIDTH'(1))) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= '0;
            burst_addr <= '0;
            length     <= '0;
            fill_left  <= '0;
            write_left <= '0;
            seed       <= '0;
            mode       <= MODE_STREAM;
            gen        <= '0;
            last_be    <= '0;
            in_burst   <= 1'b0;
            beats_left <= '0;
            burst_cnt  <= '0;
        end else begin
            if (accept) begin
                addr       <= cmd_addr & ~LANE_MASK;
                length     <= cmd_len;
                fill_left  <= cmd_words;
                write_left <= cmd_words;
                seed       <= cmd_seed;
                mode       <= cmd_mode;
                if ((cmd_mode == MODE_LFSR) && (cmd_seed == '0)) begin
                    gen <= DATA_WIDTH'(1);
                end else begin
                    gen <= DATA_WIDTH'(cmd_seed);
                end
                if (cmd_rem == '0) begin
                    last_be <= '1;
                end else begin
                    last_be <= BYTE_ENABLE_WIDTH'((1 << cmd_rem) - 1);
                end
            end
            if (push) begin
                fill_left <= fill_left - 1'b1;
                gen <= (mode == MODE_LFSR) ? lfsr_next : gen + 1'b1;
            end
            if (beat) begin
                write_left <= write_left - 1'b1;
            end
            if (launch) begin
                in_burst   <= 1'b1;
                burst_addr <= addr;
                burst_cnt  <= bc;
                beats_left <= bc;
                addr <= addr + (ADDRESS_WIDTH'(bc) << BYTE_ENABLE_WIDTH_LOG2);
            end else if (beat) begin
                beats_left <= beats_left - 1'b1;
                if (last_beat) begin
                    in_burst <= 1'b0;
                end
            end
        end
    end

    assign snk_command_ready  = (state == ST_IDLE);
    assign src_response_valid = (state == ST_RESP);
    assign src_response_data  = src_response_valid ? length : '0;
    assign master_address     = burst_addr;
    assign master_burstcount  = burst_cnt;
    assign master_write       = in_burst;
    assign master_writedata   = in_burst ? fifo_q : '0;
    assign master_byteenable  = !in_burst ? '0
                              : (write_left == LENGTH_WIDTH'(1)) ? last_be : '1;

endmodule

// File: tb/tb_burst_pattern_writer.sv
// Self-checking bench for burst_pattern_writer: vector table,
// randomized commands and reset-abort sequence against a model.
module tb_burst_pattern_writer;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  bc;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] seed;
        logic [1:0]  mode;
        int          wk;
        int          sk;
        int          exp_beats;
        logic [31:0] exp_resp;
        int          exp_bc;
        logic [31:0] exp_data;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [129:0] cmd_data = '0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  snk_data = '0;
    logic         snk_valid = 1'b0;
    logic         snk_ready;
    logic [31:0]  m_addr;
    logic         m_write;
    logic [31:0]  m_wdata;
    logic [2:0]   m_bc;
    logic [3:0]   m_be;
    logic         waitreq = 1'b0;
    logic [31:0]  resp_data;
    logic         resp_valid;

    int total = 0;
    int bad = 0;
    int wait_kind = 0;
    int stream_kind = 0;
    int stall_cnt = 0;
    int beats_seen = 0;
    int stream_idx = 0;
    int stream_acc = 0;
    int proto_err = 0;
    int burst_rem = 0;
    logic was_stall = 1'b0;
    logic [31:0] held_addr = '0;
    logic [2:0]  held_bc = '0;
    logic [31:0] held_data = '0;
    logic [3:0]  held_be = '0;
    beat_t obs_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] stream_q[$];
    vec_t vecs[8];

    burst_pattern_writer dut (
        .clk                (clk),
        .reset              (rst),
        .snk_command_data   (cmd_data),
        .snk_command_valid  (cmd_valid),
        .snk_command_ready  (cmd_ready),
        .snk_data           (snk_data),
        .snk_valid          (snk_valid),
        .snk_ready          (snk_ready),
        .master_address     (m_addr),
        .master_write       (m_write),
        .master_writedata   (m_wdata),
        .master_burstcount  (m_bc),
        .master_byteenable  (m_be),
        .master_waitrequest (waitreq),
        .src_response_data  (resp_data),
        .src_response_valid (resp_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input driver: waitrequest and stream source, just after posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (wait_kind)
                1: waitreq = ($urandom_range(0, 2) == 0);
                2: begin
                    if (beats_seen == 1 && stall_cnt < 5) begin
                        waitreq = 1'b1;
                        stall_cnt++;
                    end else begin
                        waitreq = 1'b0;
                    end
                end
                default: waitreq = 1'b0;
            endcase
            case (stream_kind)
                1: snk_valid = !snk_valid;
                2: snk_valid = ($urandom_range(0, 1) == 1);
                default: snk_valid = 1'b1;
            endcase
            snk_data = (stream_idx < stream_q.size())
                     ? stream_q[stream_idx] : 32'hDEAD0000;
        end
    end

    // Monitor: samples on negedge, records beats and responses.
    initial begin
        forever begin
            @(negedge clk);
            if (burst_rem == 0 && m_write) begin
                held_addr = m_addr;
                held_bc = m_bc;
                burst_rem = int'(m_bc);
            end
            if (burst_rem > 0) begin
                if (!m_write || m_addr != held_addr || m_bc != held_bc)
                    proto_err++;
            end
            if (was_stall && m_write &&
                (m_wdata != held_data || m_be != held_be))
                proto_err++;
            was_stall = m_write && waitreq;
            held_data = m_wdata;
            held_be = m_be;
            if (m_write && !waitreq) begin
                obs_q.push_back({held_addr, held_bc, m_wdata, m_be});
                if (burst_rem > 0) burst_rem--;
                beats_seen++;
            end
            if (snk_valid && snk_ready) begin
                stream_idx++;
                stream_acc++;
            end
            if (resp_valid) resp_q.push_back(resp_data);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [31:0] len,
                           input logic [31:0] sd, input logic [1:0] md,
                           input int wk, input int sk);
        beat_t exp_q[$];
        logic [31:0] dq[$];
        logic [31:0] ba;
        logic [31:0] g;
        int words;
        int left;
        int bc;
        int room;
        int k;
        int tmo;
        words = (int'(len) + 3) / 4;
        @(negedge clk);
        obs_q.delete();
        resp_q.delete();
        stream_q.delete();
        for (int i = 0; i < words + 3; i++)
            stream_q.push_back(32'hC0DE0000 + i);
        stream_idx = 0;
        stream_acc = 0;
        beats_seen = 0;
        stall_cnt = 0;
        proto_err = 0;
        burst_rem = 0;
        was_stall = 1'b0;
        wait_kind = wk;
        stream_kind = sk;
        cmd_data = {md, sd, len, 32'h0, a};
        cmd_valid = 1'b1;
        tmo = 0;
        while (!cmd_ready && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tmo = 0;
        while (resp_q.size() == 0 && tmo < 3000) begin
            @(negedge clk);
            tmo++;
        end
        repeat (8) @(negedge clk);

        g = (md == 2'd2 && sd == 32'h0) ? 32'd1 : sd;
        for (int i = 0; i < words; i++) begin
            case (md)
                2'd0: dq.push_back(32'hC0DE0000 + i);
                2'd1: dq.push_back(sd + i);
                2'd2: begin
                    dq.push_back(g);
                    g = {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
                end
                default: dq.push_back(sd);
            endcase
        end
        ba = a & ~32'h3;
        left = words;
        k = 0;
        while (left > 0) begin
            room = (16 - int'(ba % 16)) / 4;
            bc = (left < 4) ? left : 4;
            if (room < bc) bc = room;
            for (int j = 0; j < bc; j++) begin
                exp_q.push_back({ba, 3'(bc), dq[k],
                    (k == words - 1 && len % 4 != 0)
                        ? 4'((1 << (len % 4)) - 1) : 4'hF});
                k++;
            end
            ba = ba + 32'(bc * 4);
            left -= bc;
        end

        check("beat_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("beat%0d", i), obs_q[i], exp_q[i]);
        check("resp_count", resp_q.size(), 1);
        if (resp_q.size() > 0) check("resp_len", resp_q[0], len);
        check("protocol", proto_err, 0);
        check("stream_taken", stream_acc, (md == 2'd0) ? words : 0);
        if (tmo >= 3000) do_reset();
    endtask

    initial begin
        vecs[0] = '{32'h0, 32'd64, 32'd5, 2'd1, 0, 0, 16, 32'd64, 4, 32'd5};
        vecs[1] = '{32'h8, 32'd40, 32'hA5A5A5A5, 2'd3, 0, 0, 10, 32'd40,
                    2, 32'hA5A5A5A5};
        vecs[2] = '{32'h0, 32'd10, 32'h0, 2'd0, 0, 1, 3, 32'd10,
                    3, 32'hC0DE0000};
        vecs[3] = '{32'h100, 32'd32, 32'h77, 2'd1, 2, 0, 8, 32'd32,
                    4, 32'h77};
        vecs[4] = '{32'h40, 32'd0, 32'd9, 2'd1, 0, 0, 0, 32'd0, 0, 32'd0};
        vecs[5] = '{32'h40, 32'd20, 32'h0, 2'd2, 0, 0, 5, 32'd20, 4, 32'd1};
        vecs[6] = '{32'hFFFFFFF8, 32'd24, 32'hFFFFFFFE, 2'd1, 1, 0, 6,
                    32'd24, 2, 32'hFFFFFFFE};
        vecs[7] = '{32'h13, 32'd7, 32'h12345678, 2'd3, 0, 0, 2, 32'd7,
                    2, 32'h12345678};

        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_write", m_write, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_snk_ready", snk_ready, 1'b0);
        check("rst_addr", m_addr, 32'h0);
        check("rst_wdata", m_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_cmd(vecs[v].addr, vecs[v].len, vecs[v].seed, vecs[v].mode,
                    vecs[v].wk, vecs[v].sk);
            check($sformatf("v%0d_beats", v), obs_q.size(),
                  vecs[v].exp_beats);
            check($sformatf("v%0d_resp", v),
                  (resp_q.size() > 0) ? resp_q[0] : 32'hFFFFFFFF,
                  vecs[v].exp_resp);
            if (vecs[v].exp_beats > 0 && obs_q.size() > 0) begin
                check($sformatf("v%0d_first_bc", v), obs_q[0].bc,
                      vecs[v].exp_bc);
                check($sformatf("v%0d_first_data", v), obs_q[0].data,
                      vecs[v].exp_data);
            end
        end

        for (int r = 0; r < 20; r++) begin
            run_cmd($urandom, 32'($urandom_range(0, 90)),
                    ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom,
                    2'($urandom_range(0, 3)), 1, 2);
        end

        begin
            int tmo;
            @(negedge clk);
            wait_kind = 1;
            cmd_data = {2'd1, 32'h300, 32'd64, 32'h0, 32'h200};
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            tmo = 0;
            while (!m_write && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            check("write_before_reset", m_write, 1'b1);
            rst = 1'b0;
            #1;
            check("abort_write", m_write, 1'b0);
            check("abort_cmd_ready", cmd_ready, 1'b1);
            check("abort_addr", m_addr, 32'h0);
            check("abort_bc", m_bc, 3'h0);
            check("abort_be", m_be, 4'h0);
            check("abort_resp_valid", resp_valid, 1'b0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            resp_q.delete();
            repeat (10) @(negedge clk);
            check("abort_no_resp", resp_q.size(), 0);
            run_cmd(32'h204, 32'd24, 32'h900, 2'd1, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
